// File: rtl/nem_ohmux_ctrl_pkg.sv
// nem_ohmux_ctrl_pkg: shared state encoding, default relay timings and parameter range check
package nem_ohmux_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, PULLIN, GRANTED, RELEASE} state_t;
  localparam int DEF_T_ON  = 6;
  localparam int DEF_T_OFF = 4;
  function automatic bit cycles_ok(input int v, input int w);
    return v >= 1 && v < (1 << w);
  endfunction
endpackage

// File: rtl/nem_relay_timer.sv
// nem_relay_timer: loadable saturating down counter with zero flag, resets to its load value
module nem_relay_timer #(
  parameter int CNT_W = 4,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  assign zero = cnt == '0;
  // load wins over counting; the count parks at zero until reloaded
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= RST_VAL;
    else if (ld) cnt <= ld_val;
    else if (!zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/nem_ohmux_2i_sel_arbiter.sv
// nem_ohmux_2i_sel_arbiter: break-before-make relay select arbiter for a shared 2-input NEM mux
module nem_ohmux_2i_sel_arbiter
  import nem_ohmux_ctrl_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int T_ON     = DEF_T_ON,
  parameter int T_OFF    = DEF_T_OFF,
  parameter int HOLD_MAX = 0
) (
  input  logic       CP,
  input  logic       CDN,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       S0,
  output logic       S1,
  output logic       busy
);
  if (!cycles_ok(T_ON, CNT_W)) begin : g_bad_t_on
    $error("T_ON must fit in 1..2^CNT_W-1");
  end
  if (!cycles_ok(T_OFF, CNT_W)) begin : g_bad_t_off
    $error("T_OFF must fit in 1..2^CNT_W-1");
  end
  if (HOLD_MAX < 0) begin : g_bad_hold
    $error("HOLD_MAX must be non-negative");
  end

  localparam int HW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_MAX > 0 ? HOLD_MAX - 1 : 0);
  localparam logic [CNT_W-1:0] LD_ON     = CNT_W'(T_ON - 1);
  localparam logic [CNT_W-1:0] LD_OFF    = CNT_W'(T_OFF - 1);

  state_t           state, state_n;
  logic             tgt, tgt_n, last, last_n, pick, ld, t_zero, hold_on, s_on;
  logic [CNT_W-1:0] ld_val;
  logic [HW-1:0]    hold, hold_n;
  logic             s0_n, s1_n, busy_n;
  logic [1:0]       gnt_n;

  assign pick    = &req ? ~last : req[1];
  assign hold_on = (HOLD_MAX != 0) && req[~tgt];

  nem_relay_timer #(.CNT_W(CNT_W), .RST_VAL(LD_OFF)) u_timer (
    .clk   (CP),
    .rst_n (CDN),
    .ld    (ld),
    .ld_val(ld_val),
    .zero  (t_zero)
  );

  // next-state, timer loads and the registered output values they imply
  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    last_n  = last;
    hold_n  = hold;
    ld      = 1'b0;
    ld_val  = LD_ON;
    case (state)
      IDLE:
        if (|req) begin
          tgt_n   = pick;
          ld      = 1'b1;
          state_n = PULLIN;
        end
      PULLIN:
        if (!req[tgt]) begin
          ld      = 1'b1;
          ld_val  = LD_OFF;
          state_n = RELEASE;
        end else if (t_zero) begin
          last_n  = tgt;
          hold_n  = '0;
          state_n = GRANTED;
        end
      GRANTED:
        if (!req[tgt] || (hold_on && hold == HOLD_LAST)) begin
          ld      = 1'b1;
          ld_val  = LD_OFF;
          state_n = RELEASE;
        end else if (hold_on) hold_n = hold + 1'b1;
      RELEASE:
        if (t_zero) begin
          if (|req) begin
            tgt_n   = pick;
            ld      = 1'b1;
            state_n = PULLIN;
          end else state_n = IDLE;
        end
    endcase
    s_on   = state_n == PULLIN || state_n == GRANTED;
    s0_n   = s_on & ~tgt_n;
    s1_n   = s_on & tgt_n;
    gnt_n  = state_n == GRANTED ? {tgt_n, ~tgt_n} : 2'b00;
    busy_n = state_n != IDLE;
  end

  // reset lands in RELEASE so relays caught mid-travel still get the full release time
  always_ff @(posedge CP or negedge CDN)
    if (!CDN) begin
      state <= RELEASE;
      tgt   <= 1'b0;
      last  <= 1'b1;
      hold  <= '0;
      S0    <= 1'b0;
      S1    <= 1'b0;
      gnt   <= 2'b00;
      busy  <= 1'b1;
    end else begin
      state <= state_n;
      tgt   <= tgt_n;
      last  <= last_n;
      hold  <= hold_n;
      S0    <= s0_n;
      S1    <= s1_n;
      gnt   <= gnt_n;
      busy  <= busy_n;
    end
endmodule

// File: tb/tb_nem_ohmux_2i_sel_arbiter.sv
// tb_nem_ohmux_2i_sel_arbiter: directed timing checks plus a random break-before-make invariant run
module tb_nem_ohmux_2i_sel_arbiter;
  logic       CP = 1'b0, CDN = 1'b1;
  logic [1:0] req = 2'b00, gnt;
  logic       S0, S1, busy;
  int         checks = 0, failures = 0;
  int         zc, left;
  logic [1:0] prev;

  nem_ohmux_2i_sel_arbiter #(.CNT_W(4), .T_ON(6), .T_OFF(4), .HOLD_MAX(8)) dut (
    .CP  (CP),
    .CDN (CDN),
    .req (req),
    .gnt (gnt),
    .S0  (S0),
    .S1  (S1),
    .busy(busy)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge CP);
    #1;
  endtask

  initial begin
    #2 CDN = 1'b0;
    #1;
    chk("rst_s", {S1, S0}, 2'b00);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 1'b1);
    step(2);
    CDN = 1'b1;
    req = 2'b01;
    step(3);  chk("t1_s_wait", {S1, S0}, 2'b00);
    step();   chk("t1_s0", {S1, S0}, 2'b01);
    step(5);  chk("t1_gnt_early", gnt, 2'b00);
    step();   chk("t1_gnt", gnt, 2'b01);
    step(2);
    CDN = 1'b0;
    #1;
    chk("t1_rst_s", {S1, S0}, 2'b00);
    chk("t1_rst_gnt", gnt, 2'b00);
    chk("t1_rst_busy", busy, 1'b1);
    step();
    CDN = 1'b1;
    req = 2'b00;
    step(3);  chk("t1_rel_busy", busy, 1'b1);
    step();   chk("t1_idle", busy, 1'b0);

    req = 2'b01;
    step();   chk("t2_s0", {S1, S0}, 2'b01);
              chk("t2_busy", busy, 1'b1);
    step(5);  chk("t2_gnt_early", gnt, 2'b00);
    step();   chk("t2_gnt", gnt, 2'b01);
    req = 2'b00;
    step();   chk("t2_drop_s", {S1, S0}, 2'b00);
              chk("t2_drop_gnt", gnt, 2'b00);
              chk("t2_drop_busy", busy, 1'b1);
    step(3);  chk("t2_rel_busy", busy, 1'b1);
    step();   chk("t2_idle", busy, 1'b0);

    CDN = 1'b0;
    #1;
    req = 2'b11;
    step();
    CDN = 1'b1;
    step(3);  chk("t3_s_wait", {S1, S0}, 2'b00);
    step();   chk("t3_first_i0", {S1, S0}, 2'b01);
    step(5);  chk("t3_gnt_early", gnt, 2'b00);
    step();   chk("t3_gnt0", gnt, 2'b01);
    req = 2'b10;
    step();   chk("t3_drop_s", {S1, S0}, 2'b00);
              chk("t3_drop_gnt", gnt, 2'b00);
    step(3);  chk("t3_gap", {S1, S0}, 2'b00);
    step();   chk("t3_s1", {S1, S0}, 2'b10);
    step(5);  chk("t3_gnt1_early", gnt, 2'b00);
    step();   chk("t3_gnt1", gnt, 2'b10);

    req = 2'b01;
    step();   chk("t4_swap_s", {S1, S0}, 2'b00);
    step(3);  chk("t4_swap_gap", {S1, S0}, 2'b00);
    step();   chk("t4_swap_s0", {S1, S0}, 2'b01);
    step(6);  chk("t4_gnt0", gnt, 2'b01);
    req = 2'b10;
    step(5);  chk("t4_pull_s1", {S1, S0}, 2'b10);
    step(2);  chk("t4_pullin_gnt", gnt, 2'b00);
    req = 2'b00;
    step();   chk("t4_abort_s", {S1, S0}, 2'b00);
              chk("t4_abort_gnt", gnt, 2'b00);
    req = 2'b11;
    step(3);  chk("t4_abort_gap", {S1, S0}, 2'b00);
              chk("t4_abort_gnt2", gnt, 2'b00);
    step();   chk("t4_last", {S1, S0}, 2'b10);

    step(5);  chk("t5_gnt1_early", gnt, 2'b00);
    step();   chk("t5_gnt1", gnt, 2'b10);
    step(7);  chk("t5_hold1", gnt, 2'b10);
    step();   chk("t5_force1", gnt, 2'b00);
              chk("t5_force1_s", {S1, S0}, 2'b00);
    step(3);  chk("t5_gap1", {S1, S0}, 2'b00);
    step();   chk("t5_s0", {S1, S0}, 2'b01);
    step(5);  chk("t5_gnt0_early", gnt, 2'b00);
    step();   chk("t5_gnt0", gnt, 2'b01);
    step(7);  chk("t5_hold0", gnt, 2'b01);
    step();   chk("t5_force0", gnt, 2'b00);
    step(3);  chk("t5_gap0", {S1, S0}, 2'b00);
    step();   chk("t5_s1", {S1, S0}, 2'b10);
    step(5);  chk("t5_gnt1b_early", gnt, 2'b00);
    step();   chk("t5_gnt1b", gnt, 2'b10);

    zc   = 0;
    left = 0;
    prev = {S1, S0};
    for (int c = 0; c < 10000; c++) begin
      if (left == 0) begin
        req  = 2'($urandom_range(0, 3));
        left = $urandom_range(1, 20);
      end
      left--;
      step();
      chk("s_excl", 8'(S0 & S1), 8'd0);
      if ({S1, S0} == 2'b00) zc++;
      else begin
        if (prev == 2'b00) chk("s_gap", 8'(zc >= 4), 8'd1);
        else chk("s_switch", {S1, S0}, prev);
        zc = 0;
      end
      prev = {S1, S0};
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
